// File: rtl/aes_arb_pkg.sv
// Shared types and constants for the AES core arbiter slice.
// Requester IDs double as tag FIFO entries; mode constants qualify *_dec inputs.
package aes_arb_pkg;

    typedef logic req_id_t;

    localparam logic    MODE_ENC   = 1'b0;
    localparam logic    MODE_DEC   = 1'b1;
    localparam req_id_t REQ_BRIDGE = 1'b0;
    localparam req_id_t REQ_REGS   = 1'b1;

endpackage

// File: rtl/taxi_axis_if.sv
// Minimal AXI-Stream bundle: one beat per tvalid/tready handshake.
// src drives payload and tvalid, snk drives tready.
interface taxi_axis_if #(
    parameter int DATA_W = 128,
    parameter int KEEP_W = DATA_W / 8
);
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport src (output tdata, tkeep, tlast, tvalid, input tready);
    modport snk (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/aes_arb_tag_fifo.sv
// In-order FIFO of requester IDs for blocks in flight; head is combinational from storage.
// Push is ignored when full and pop when empty; pointers wrap at the power-of-2 depth.
module aes_arb_tag_fifo
    import aes_arb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  req_id_t          i_din,
    output req_id_t          o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    req_id_t          r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/aes_core_arbiter.sv
// Round-robin share of one in-order AES core between bridge (0) and register (1) requesters.
// Zero-latency issue/response muxing; grant held while the core stalls, response head-of-line stalls the core.
module aes_core_arbiter
    import aes_arb_pkg::*;
#(
    parameter  int DATA_W  = 128,
    parameter  int MAX_OUT = 4,
    localparam int CNT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    taxi_axis_if.snk         s_req0,
    input  logic             s_req0_dec,
    taxi_axis_if.snk         s_req1,
    input  logic             s_req1_dec,
    taxi_axis_if.src         m_core,
    output logic             m_core_dec,
    taxi_axis_if.snk         s_core_rsp,
    taxi_axis_if.src         m_rsp0,
    taxi_axis_if.src         m_rsp1,
    output logic [CNT_W-1:0] outstanding,
    output logic             busy,
    output logic             err_orphan
);

    localparam int KEEP_W = DATA_W / 8;

    req_id_t          r_rr;
    req_id_t          r_lock_id;
    logic             r_lock;
    logic             r_err_orphan;
    req_id_t          w_gnt;
    req_id_t          w_head;
    logic             w_gnt_vld;
    logic             w_issue;
    logic             w_full;
    logic             w_empty;
    logic             w_rsp_vld;
    logic             w_rsp_rdy;
    logic             w_rsp_pop;
    logic [CNT_W-1:0] w_count;
    logic [DATA_W-1:0] w_rsp_dat;
    logic [KEEP_W-1:0] w_rsp_keep;

    // A locked grant ignores en, fullness and the other requester until it handshakes.
    always_comb begin
        w_gnt     = r_rr;
        w_gnt_vld = 1'b0;
        if (r_lock) begin
            w_gnt     = r_lock_id;
            w_gnt_vld = (r_lock_id == REQ_REGS) ? s_req1.tvalid : s_req0.tvalid;
        end else if (en && !w_full) begin
            if (s_req0.tvalid && s_req1.tvalid) begin
                w_gnt     = r_rr;
                w_gnt_vld = 1'b1;
            end else if (s_req0.tvalid) begin
                w_gnt     = REQ_BRIDGE;
                w_gnt_vld = 1'b1;
            end else if (s_req1.tvalid) begin
                w_gnt     = REQ_REGS;
                w_gnt_vld = 1'b1;
            end
        end
    end

    always_comb begin
        m_core.tvalid = w_gnt_vld;
        if (w_gnt == REQ_REGS) begin
            m_core.tdata = s_req1.tdata;
            m_core.tkeep = s_req1.tkeep;
            m_core.tlast = s_req1.tlast;
            m_core_dec   = s_req1_dec;
        end else begin
            m_core.tdata = s_req0.tdata;
            m_core.tkeep = s_req0.tkeep;
            m_core.tlast = s_req0.tlast;
            m_core_dec   = s_req0_dec;
        end
        s_req0.tready = w_gnt_vld && (w_gnt == REQ_BRIDGE) && m_core.tready;
        s_req1.tready = w_gnt_vld && (w_gnt == REQ_REGS) && m_core.tready;
    end

    assign w_issue = w_gnt_vld && m_core.tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr         <= REQ_BRIDGE;
            r_lock       <= 1'b0;
            r_lock_id    <= REQ_BRIDGE;
            r_err_orphan <= 1'b0;
        end else begin
            r_lock <= w_gnt_vld && !m_core.tready;
            if (w_gnt_vld) r_lock_id <= w_gnt;
            if (w_issue)   r_rr      <= ~w_gnt;
            if (s_core_rsp.tvalid && w_empty) r_err_orphan <= 1'b1;
        end
    end

    aes_arb_tag_fifo #(
        .DEPTH (MAX_OUT)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_issue),
        .i_pop   (w_rsp_pop),
        .i_din   (w_gnt),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // With no tag to route by, the core output is sunk so an orphan beat cannot wedge it.
    assign w_rsp_vld  = s_core_rsp.tvalid && !w_empty;
    assign w_rsp_rdy  = w_empty ? 1'b1 : ((w_head == REQ_REGS) ? m_rsp1.tready : m_rsp0.tready);
    assign w_rsp_pop  = w_rsp_vld && w_rsp_rdy;
    assign w_rsp_dat  = s_core_rsp.tdata;
    assign w_rsp_keep = s_core_rsp.tkeep;
    assign s_core_rsp.tready = w_rsp_rdy;

    always_comb begin
        m_rsp0.tvalid = 1'b0;
        m_rsp0.tdata  = '0;
        m_rsp0.tkeep  = '0;
        m_rsp0.tlast  = 1'b0;
        m_rsp1.tvalid = 1'b0;
        m_rsp1.tdata  = '0;
        m_rsp1.tkeep  = '0;
        m_rsp1.tlast  = 1'b0;
        if (!w_empty) begin
            if (w_head == REQ_REGS) begin
                m_rsp1.tvalid = w_rsp_vld;
                m_rsp1.tdata  = w_rsp_dat;
                m_rsp1.tkeep  = w_rsp_keep;
                m_rsp1.tlast  = s_core_rsp.tlast;
            end else begin
                m_rsp0.tvalid = w_rsp_vld;
                m_rsp0.tdata  = w_rsp_dat;
                m_rsp0.tkeep  = w_rsp_keep;
                m_rsp0.tlast  = s_core_rsp.tlast;
            end
        end
    end

    assign outstanding = w_count;
    assign busy        = (w_count != '0) || m_core.tvalid;
    assign err_orphan  = r_err_orphan;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Bench for aes_core_arbiter: table-driven arbitration vectors plus hand sequences,
// with a scoreboard of expected responses and a simple in-order core model.
module tb_aes_core_arbiter;
    import aes_arb_pkg::*;

    localparam int DATA_W  = 128;
    localparam int MAX_OUT = 4;
    localparam int CNT_W   = $clog2(MAX_OUT + 1);
    localparam logic [DATA_W-1:0] KEY = {4{32'h5A5A_C3C3}};

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             s_req0_dec;
    logic             s_req1_dec;
    logic             m_core_dec;
    logic [CNT_W-1:0] outstanding;
    logic             busy;
    logic             err_orphan;

    taxi_axis_if #(.DATA_W(DATA_W)) s_req0 ();
    taxi_axis_if #(.DATA_W(DATA_W)) s_req1 ();
    taxi_axis_if #(.DATA_W(DATA_W)) m_core ();
    taxi_axis_if #(.DATA_W(DATA_W)) s_core_rsp ();
    taxi_axis_if #(.DATA_W(DATA_W)) m_rsp0 ();
    taxi_axis_if #(.DATA_W(DATA_W)) m_rsp1 ();

    always #5 clk = ~clk;

    aes_core_arbiter #(.DATA_W(DATA_W), .MAX_OUT(MAX_OUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .s_req0      (s_req0),
        .s_req0_dec  (s_req0_dec),
        .s_req1      (s_req1),
        .s_req1_dec  (s_req1_dec),
        .m_core      (m_core),
        .m_core_dec  (m_core_dec),
        .s_core_rsp  (s_core_rsp),
        .m_rsp0      (m_rsp0),
        .m_rsp1      (m_rsp1),
        .outstanding (outstanding),
        .busy        (busy),
        .err_orphan  (err_orphan)
    );

    typedef struct {
        logic              port;
        logic [DATA_W-1:0] dat;
    } exp_t;

    typedef struct {
        logic en, v0, v1, d0, d1, crdy;
        logic cvld, src, dec, rdy0, rdy1;
        logic [31:0] out;
    } vec_t;

    exp_t              exp_q [$];
    logic [DATA_W-1:0] core_q [$];
    vec_t              tbl [7];
    int checks = 0;
    int failures = 0;
    int seq0 = 0, seq1 = 0, hs0 = 0, hs1 = 0;
    logic core_en = 1'b0;
    logic orphan_drv = 1'b0;

    function automatic logic [DATA_W-1:0] dat_of(input logic id, input int seq);
        logic [31:0] w;
        w = (id ? 32'hB100_0000 : 32'hA000_0000) + 32'(seq);
        return {4{w}};
    endfunction

    function automatic vec_t mk(input logic [5:0] ib, input logic [4:0] eb, input int out);
        vec_t v;
        {v.en, v.v0, v.v1, v.d0, v.d1, v.crdy} = ib;
        {v.cvld, v.src, v.dec, v.rdy0, v.rdy1} = eb;
        v.out = 32'(out);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic chkd(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic rsp_seen(input logic port, input logic [DATA_W-1:0] dat);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_unexpected: got response on port %0d, required none", port);
        end else begin
            e = exp_q.pop_front();
            chk("rsp_port", 32'(port), 32'(e.port));
            chkd("rsp_data", dat, e.dat ^ KEY);
        end
    endtask

    task automatic drive_reqs();
        s_req0.tdata = dat_of(1'b0, seq0);
        s_req1.tdata = dat_of(1'b1, seq1);
    endtask

    task automatic drive_core();
        if (orphan_drv) begin
            s_core_rsp.tvalid = 1'b1;
            s_core_rsp.tdata  = {4{32'hDEAD_BEEF}};
        end else if (core_en && core_q.size() > 0) begin
            s_core_rsp.tvalid = 1'b1;
            s_core_rsp.tdata  = core_q[0] ^ KEY;
        end else begin
            s_core_rsp.tvalid = 1'b0;
            s_core_rsp.tdata  = '0;
        end
    endtask

    // Called 2 time units after a rising edge: records this cycle's handshakes, then advances.
    task automatic cycle();
        if (m_rsp0.tvalid && m_rsp0.tready) rsp_seen(1'b0, m_rsp0.tdata);
        if (m_rsp1.tvalid && m_rsp1.tready) rsp_seen(1'b1, m_rsp1.tdata);
        if (s_core_rsp.tvalid && s_core_rsp.tready && !orphan_drv && core_q.size() > 0)
            void'(core_q.pop_front());
        if (m_core.tvalid && m_core.tready) core_q.push_back(m_core.tdata);
        if (s_req0.tvalid && s_req0.tready) begin
            exp_q.push_back('{1'b0, dat_of(1'b0, seq0)});
            seq0++;
            hs0++;
        end
        if (s_req1.tvalid && s_req1.tready) begin
            exp_q.push_back('{1'b1, dat_of(1'b1, seq1)});
            seq1++;
            hs1++;
        end
        @(posedge clk);
        #1;
        drive_reqs();
        drive_core();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        s_req0.tvalid = 1'b0;
        s_req1.tvalid = 1'b0;
        s_req0_dec = MODE_ENC;
        s_req1_dec = MODE_ENC;
        m_core.tready = 1'b0;
        m_rsp0.tready = 1'b0;
        m_rsp1.tready = 1'b0;
        core_en = 1'b0;
        orphan_drv = 1'b0;
        drive_core();
        drive_reqs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        core_q.delete();
        hs0 = 0;
        hs1 = 0;
    endtask

    initial begin
        int n;
        s_req0.tkeep = '1;
        s_req0.tlast = 1'b1;
        s_req1.tkeep = '1;
        s_req1.tlast = 1'b1;
        s_core_rsp.tkeep = '1;
        s_core_rsp.tlast = 1'b1;

        tbl[0] = mk(6'b111011, 5'b10010, 0);
        tbl[1] = mk(6'b111011, 5'b11101, 1);
        tbl[2] = mk(6'b011101, 5'b00000, 2);
        tbl[3] = mk(6'b101010, 5'b11100, 2);
        tbl[4] = mk(6'b011111, 5'b11101, 2);
        tbl[5] = mk(6'b110001, 5'b10010, 3);
        tbl[6] = mk(6'b111011, 5'b00000, 4);

        // Reset values
        do_reset();
        #1;
        chk("rst_core_vld", 32'(m_core.tvalid), 0);
        chk("rst_rsp0_vld", 32'(m_rsp0.tvalid), 0);
        chk("rst_rsp1_vld", 32'(m_rsp1.tvalid), 0);
        chk("rst_outstanding", 32'(outstanding), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err_orphan", 32'(err_orphan), 0);
        cycle();

        // Arbitration, lock and fill vectors
        for (int i = 0; i < 7; i++) begin
            en = tbl[i].en;
            s_req0.tvalid = tbl[i].v0;
            s_req1.tvalid = tbl[i].v1;
            s_req0_dec = tbl[i].d0;
            s_req1_dec = tbl[i].d1;
            m_core.tready = tbl[i].crdy;
            #1;
            chk($sformatf("vec%0d_core_vld", i), 32'(m_core.tvalid), 32'(tbl[i].cvld));
            chk($sformatf("vec%0d_rdy0", i), 32'(s_req0.tready), 32'(tbl[i].rdy0));
            chk($sformatf("vec%0d_rdy1", i), 32'(s_req1.tready), 32'(tbl[i].rdy1));
            chk($sformatf("vec%0d_outstanding", i), 32'(outstanding), tbl[i].out);
            if (tbl[i].cvld) begin
                chkd($sformatf("vec%0d_core_dat", i), m_core.tdata,
                     dat_of(tbl[i].src, tbl[i].src ? seq1 : seq0));
                chk($sformatf("vec%0d_core_dec", i), 32'(m_core_dec), 32'(tbl[i].dec));
            end
            cycle();
        end

        // Drain the four blocks in issue order
        s_req0.tvalid = 1'b0;
        s_req1.tvalid = 1'b0;
        m_rsp0.tready = 1'b1;
        m_rsp1.tready = 1'b1;
        core_en = 1'b1;
        drive_core();
        n = 0;
        while ((exp_q.size() != 0 || core_q.size() != 0) && n < 20) begin
            #1;
            cycle();
            n++;
        end
        #1;
        chk("drain_left", 32'(exp_q.size()), 0);
        chk("drain_outstanding", 32'(outstanding), 0);
        cycle();

        // Fill to MAX_OUT with responses blocked, then one pop frees one slot a cycle later
        do_reset();
        en = 1'b1;
        s_req0.tvalid = 1'b1;
        m_core.tready = 1'b1;
        core_en = 1'b1;
        drive_core();
        for (int k = 0; k < 8; k++) begin
            #1;
            cycle();
        end
        #1;
        chk("full_issues", 32'(hs0), 4);
        chk("full_outstanding", 32'(outstanding), 4);
        chk("full_rdy0", 32'(s_req0.tready), 0);
        chk("full_rsp0_vld", 32'(m_rsp0.tvalid), 1);
        m_rsp0.tready = 1'b1;
        #1;
        chk("full_pop_cycle_rdy0", 32'(s_req0.tready), 0);
        cycle();
        m_rsp0.tready = 1'b0;
        #1;
        chk("after_pop_outstanding", 32'(outstanding), 3);
        chk("after_pop_rdy0", 32'(s_req0.tready), 1);
        cycle();
        #1;
        chk("after_pop_issues", 32'(hs0), 5);
        chk("after_pop_refill", 32'(outstanding), 4);
        cycle();

        // Lock hold: requester 1 stalled by the core while 0 asserts and en drops
        do_reset();
        en = 1'b1;
        s_req1.tvalid = 1'b1;
        s_req1_dec = MODE_DEC;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) s_req0.tvalid = 1'b1;
            if (k == 3) en = 1'b0;
            #1;
            chk($sformatf("lock%0d_vld", k), 32'(m_core.tvalid), 1);
            chkd($sformatf("lock%0d_dat", k), m_core.tdata, dat_of(1'b1, seq1));
            chk($sformatf("lock%0d_dec", k), 32'(m_core_dec), 32'(MODE_DEC));
            chk($sformatf("lock%0d_rdy0", k), 32'(s_req0.tready), 0);
            cycle();
        end
        m_core.tready = 1'b1;
        #1;
        chk("lock_release_rdy1", 32'(s_req1.tready), 1);
        chk("lock_release_rdy0", 32'(s_req0.tready), 0);
        cycle();
        #1;
        chk("lock_hs1", 32'(hs1), 1);
        chk("lock_outstanding", 32'(outstanding), 1);
        chk("lock_en0_no_issue", 32'(m_core.tvalid), 0);
        cycle();

        // en=0 with three blocks in flight: drain only
        do_reset();
        en = 1'b1;
        s_req0.tvalid = 1'b1;
        s_req1.tvalid = 1'b1;
        s_req1_dec = MODE_DEC;
        m_core.tready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            cycle();
        end
        en = 1'b0;
        m_rsp0.tready = 1'b1;
        m_rsp1.tready = 1'b1;
        core_en = 1'b1;
        drive_core();
        #1;
        chk("en0_start_outstanding", 32'(outstanding), 3);
        n = 0;
        while (outstanding != '0 && n < 10) begin
            chk("en0_no_issue", 32'(m_core.tvalid), 0);
            chk("en0_busy", 32'(busy), 1);
            cycle();
            #1;
            n++;
        end
        chk("en0_outstanding", 32'(outstanding), 0);
        chk("en0_busy_fall", 32'(busy), 0);
        chk("en0_left", 32'(exp_q.size()), 0);
        cycle();

        // Orphan response with an empty tag FIFO
        do_reset();
        m_rsp0.tready = 1'b1;
        m_rsp1.tready = 1'b1;
        orphan_drv = 1'b1;
        drive_core();
        #1;
        chk("orphan_tready", 32'(s_core_rsp.tready), 1);
        chk("orphan_rsp0_vld", 32'(m_rsp0.tvalid), 0);
        chk("orphan_rsp1_vld", 32'(m_rsp1.tvalid), 0);
        chk("orphan_pre_err", 32'(err_orphan), 0);
        cycle();
        orphan_drv = 1'b0;
        drive_core();
        #1;
        chk("orphan_err_set", 32'(err_orphan), 1);
        for (int k = 0; k < 3; k++) cycle();
        #1;
        chk("orphan_err_sticky", 32'(err_orphan), 1);
        chk("orphan_outstanding", 32'(outstanding), 0);

        // Reset with two blocks in flight and the RR pointer at requester 1
        en = 1'b1;
        m_core.tready = 1'b1;
        s_req1.tvalid = 1'b1;
        cycle();
        s_req1.tvalid = 1'b0;
        s_req0.tvalid = 1'b1;
        cycle();
        s_req0.tvalid = 1'b0;
        #1;
        chk("prerst_outstanding", 32'(outstanding), 2);
        do_reset();
        #1;
        chk("midrst_outstanding", 32'(outstanding), 0);
        chk("midrst_core_vld", 32'(m_core.tvalid), 0);
        chk("midrst_rsp0_vld", 32'(m_rsp0.tvalid), 0);
        chk("midrst_rsp1_vld", 32'(m_rsp1.tvalid), 0);
        chk("midrst_err_orphan", 32'(err_orphan), 0);
        en = 1'b1;
        s_req0.tvalid = 1'b1;
        s_req1.tvalid = 1'b1;
        #1;
        chk("midrst_rr_vld", 32'(m_core.tvalid), 1);
        chkd("midrst_rr_dat", m_core.tdata, dat_of(1'b0, seq0));
        s_req0.tvalid = 1'b0;
        s_req1.tvalid = 1'b0;
        en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_core_arbiter.md
Name: aes_core_arbiter

Overview:
Shares one pipelined 128-bit AES core between two block requesters: requester 0 is the auto-mode bridge path and requester 1 is the register (EPR/DPR) path. The block grants one single-beat request per handshake using round-robin, and tags each request with its encrypt/decrypt mode. It records the requester ID of every in-flight block in an in-order tag FIFO and routes each core response back to the requester that issued it. It sits between the regs/bridge layer and the AES core wrapper, and replaces the separate cipher and invcipher instances.

Parameters:
DATA_W, 128, block width; all AXI-Stream tdata buses are DATA_W.
MAX_OUT, 4, maximum blocks in flight inside the core; power of 2, range 2..16.
CNT_W, $clog2(MAX_OUT+1), width of the outstanding counter (derived; do not override).

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
en  in  1  1 = new requests may be issued; 0 = issue stalls, in-flight responses still drain
s_req0  taxi_axis_if.snk  DATA_W  requester 0 block in; single beat, tlast=1
s_req0_dec  in  1  requester 0 mode (0 = encrypt, 1 = decrypt); qualified by s_req0.tvalid
s_req1  taxi_axis_if.snk  DATA_W  requester 1 block in
s_req1_dec  in  1  requester 1 mode
m_core  taxi_axis_if.src  DATA_W  block to the AES core
m_core_dec  out  1  mode for the block on m_core; valid while m_core.tvalid
s_core_rsp  taxi_axis_if.snk  DATA_W  processed block from the core; in order
m_rsp0  taxi_axis_if.src  DATA_W  response to requester 0
m_rsp1  taxi_axis_if.src  DATA_W  response to requester 1
outstanding  out  CNT_W  number of blocks in flight
busy  out  1  outstanding != 0 or m_core.tvalid
err_orphan  out  1  sticky: a core response arrived while the tag FIFO was empty

Behaviour:
- Reset values:
  - m_core.tvalid=0, m_rsp0/1.tvalid=0, outstanding=0, busy=0, err_orphan=0.
  - RR pointer=0 (requester 0 preferred), grant lock cleared, tag FIFO empty.
  - Reset is synchronous; a reset mid-operation discards all tags. The core shares rst.
- Arbitration:
  - Candidates are the requesters with tvalid=1.
  - If both are valid, the requester equal to the RR pointer wins.
  - Issue is allowed only when en=1, outstanding < MAX_OUT, and no lock is held.
- Lock:
  - When m_core.tvalid=1 and m_core.tready=0, the grant is held (lock register) until the handshake completes.
  - While locked, m_core data and mode stay stable even if en drops or the other requester asserts.
  - en=0 blocks only new grants.
- Core output path: combinational passthrough from the granted requester, 0 register latency.
  - m_core.tdata, tkeep and tlast come from the granted requester; m_core_dec comes from the granted requester's mode input.
  - s_reqN.tready = m_core.tready when requester N is granted, otherwise 0.
- On an m_core handshake:
  - Push the granted ID (1 bit) into the tag FIFO.
  - Set the RR pointer to the other requester.
  - Increment outstanding.
- Response routing:
  - head = tag FIFO head.
  - m_rsp[head].tvalid = s_core_rsp.tvalid and FIFO non-empty; m_rsp[head] carries s_core_rsp tdata, tkeep and tlast unchanged.
  - The other response port has tvalid=0 and tdata=0.
  - s_core_rsp.tready = m_rsp[head].tready when the FIFO is non-empty.
  - On a response handshake: pop the FIFO and decrement outstanding.
- Empty-FIFO response:
  - When s_core_rsp.tvalid=1 and the FIFO is empty, s_core_rsp.tready=1.
  - The beat is dropped and err_orphan is set; only rst clears it.
- Full condition uses the registered count: at outstanding==MAX_OUT, issue stalls even if a pop occurs in the same cycle (1-cycle bubble accepted).
- Simultaneous push and pop below full: outstanding is unchanged and the FIFO pointers both advance.
- Ordering: the core is in-order; responses are never reordered, and head-of-line blocking on m_rsp[head] stalls the core output.
- Counter width: outstanding never exceeds MAX_OUT; the FIFO pointers are $clog2(MAX_OUT) bits and wrap naturally.

Decomposition:
- Package aes_arb_pkg:
  - typedef req_id_t (logic, 1 bit)
  - constants MODE_ENC=1'b0, MODE_DEC=1'b1, REQ_BRIDGE=1'b0, REQ_REGS=1'b1
- Sub-module aes_arb_tag_fifo:
  - Synchronous FIFO of req_id_t with depth MAX_OUT.
  - Ports: push/pop, din, head, count, full, empty.
- The arbiter, lock and routing logic stay in aes_core_arbiter.

Test Plan:
1. Both requesters valid, core tready=1, en=1, back to back:
   - Grants alternate 0,1,0,1.
   - m_core_dec follows each requester's mode.
   - Responses return to m_rsp0/m_rsp1 in the same order, with data intact.
2. Requester 0 only, core tready=1, core output stalled (rsp tready=0):
   - Exactly 4 issues occur; outstanding=4; s_req0.tready=0 thereafter.
   - After one response pops, the next issue occurs one cycle later.
3. Lock hold:
   - Setup: issue from requester 1 with m_core.tready=0 for 5 cycles, asserting requester 0 and dropping en mid-stall.
   - m_core.tdata and m_core_dec stay constant and the grant stays with 1.
   - The handshake completes only when tready rises.
4. en=0 with 3 blocks in flight:
   - No new issue.
   - All 3 responses drain to the correct ports; busy falls the cycle after the last pop.
5. Core response with the FIFO empty:
   - Beat accepted and dropped, err_orphan=1, both m_rsp tvalid stay 0.
   - err_orphan stays set until rst.
6. Reset asserted with outstanding=2:
   - Next cycle: outstanding=0, the RR pointer selects requester 0, and all tvalid outputs are 0.
